// File: rtl/operand_serializer_pkg.sv
// operand_serializer_pkg: shared types and constants for the operand serializer.
// Bundle layout is shared by the FSM and the optional skid register.
package operand_serializer_pkg;

    localparam int WIDTH   = 8;
    localparam int MAX_OPS = 3;
    localparam int CNT_W   = 2;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        COMMIT
    } state_e;

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [WIDTH-1:0] op0;
        logic [WIDTH-1:0] op1;
        logic [WIDTH-1:0] op2;
    } bundle_t;

    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
        return (c > CNT_W'(MAX_OPS)) ? CNT_W'(MAX_OPS) : c;
    endfunction

    function automatic logic [WIDTH-1:0] op_at(input bundle_t b, input logic [CNT_W-1:0] i);
        return (i == CNT_W'(0)) ? b.op0 : (i == CNT_W'(1)) ? b.op1 : b.op2;
    endfunction

endpackage

// File: rtl/operand_serializer_skid.sv
// operand_skid: one-entry bundle register with valid/ready semantics.
// A push overwrites the entry; a pop without push empties it.
module operand_skid
    import operand_serializer_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  bundle_t push_data,
    input  logic    pop,
    output logic    valid,
    output bundle_t data
);

    logic    valid_q, valid_d;
    bundle_t data_q, data_d;

    always_comb begin
        valid_d = push ? 1'b1 : (pop ? 1'b0 : valid_q);
        data_d  = push ? push_data : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/operand_serializer.sv
// operand_serializer: turns a command bundle into a put/value stream plus one commit cycle.
// Define OPERAND_SERIALIZER_SKID_EN to add a one-entry skid buffer for back-to-back commands.
module operand_serializer
    import operand_serializer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] in_count,
    input  logic [WIDTH-1:0] in_op0,
    input  logic [WIDTH-1:0] in_op1,
    input  logic [WIDTH-1:0] in_op2,
    output logic             put,
    output logic [WIDTH-1:0] value,
    output logic             cmd_done,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    bundle_t          cmd_q, cmd_d, in_bundle, next_bundle;
    logic             put_q, put_d, cmd_done_q, cmd_done_d, busy_q, busy_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             accept, take_idle, take_commit, take;

    assign in_bundle = '{count: clamp_count(in_count), op0: in_op0, op1: in_op1, op2: in_op2};
    assign accept    = in_valid && in_ready;

`ifdef OPERAND_SERIALIZER_SKID_EN
    logic    skid_valid;
    bundle_t skid_data;

    // Bundles arriving while busy park in the skid; IDLE accepts straight through.
    operand_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept && state_q != IDLE),
        .push_data (in_bundle),
        .pop       (skid_valid && state_q != SEND),
        .valid     (skid_valid),
        .data      (skid_data)
    );

    assign in_ready    = rst_n && !skid_valid;
    assign next_bundle = skid_valid ? skid_data : in_bundle;
    assign take_idle   = skid_valid || accept;
    assign take_commit = skid_valid;
`else
    assign in_ready    = rst_n && state_q == IDLE;
    assign next_bundle = in_bundle;
    assign take_idle   = accept;
    assign take_commit = 1'b0;
`endif

    assign take = (state_q == IDLE) ? take_idle : (state_q == COMMIT) ? take_commit : 1'b0;

    // Outputs are decoded from the next state so they appear registered.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cmd_d   = cmd_q;
        if (take) begin
            cmd_d   = next_bundle;
            idx_d   = '0;
            state_d = (next_bundle.count == '0) ? COMMIT : SEND;
        end else if (state_q == COMMIT) begin
            state_d = IDLE;
        end else if (state_q == SEND) begin
            state_d = (idx_q == cmd_q.count - CNT_W'(1)) ? COMMIT : SEND;
            idx_d   = (idx_q == cmd_q.count - CNT_W'(1)) ? '0 : idx_q + CNT_W'(1);
        end
        put_d      = state_d == SEND;
        value_d    = put_d ? op_at(cmd_d, idx_d) : '0;
        cmd_done_d = state_d == COMMIT;
        busy_d     = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cmd_q      <= '0;
            put_q      <= 1'b0;
            value_q    <= '0;
            cmd_done_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cmd_q      <= cmd_d;
            put_q      <= put_d;
            value_q    <= value_d;
            cmd_done_q <= cmd_done_d;
            busy_q     <= busy_d;
        end
    end

    assign put      = put_q;
    assign value    = value_q;
    assign cmd_done = cmd_done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_operand_serializer.sv
// tb_operand_serializer: directed self-checking bench for the base operand_serializer build.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_operand_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_count = '0;
    logic [7:0] in_op0 = '0, in_op1 = '0, in_op2 = '0;
    logic       put;
    logic [7:0] value;
    logic       cmd_done;
    logic       busy;

    int checks = 0;
    int failures = 0;

    operand_serializer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_count (in_count),
        .in_op0   (in_op0),
        .in_op1   (in_op1),
        .in_op2   (in_op2),
        .put      (put),
        .value    (value),
        .cmd_done (cmd_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expo(input string tag, input logic p, input logic [7:0] v,
                        input logic d, input logic r, input logic b);
        chk({tag, ".put"}, 32'(put), 32'(p));
        chk({tag, ".value"}, 32'(value), 32'(v));
        chk({tag, ".cmd_done"}, 32'(cmd_done), 32'(d));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(r));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
        in_valid = 1'b1;
        in_count = c;
        in_op0 = a;
        in_op1 = b;
        in_op2 = d;
    endtask

    initial begin
        int n_done;
        int n_put;
        logic [7:0] ops [3];
        logic [1:0] cnt;

        #2 rst_n = 1'b0;
        step();
        expo("reset", 0, 8'h00, 0, 0, 0);
        step();
        rst_n = 1'b1;
        #1 expo("release", 0, 8'h00, 0, 1, 0);

        drive(2'd3, 8'h11, 8'h22, 8'h33);
        step(); in_valid = 1'b0;
        expo("c3.t1", 1, 8'h11, 0, 0, 1);
        step(); expo("c3.t2", 1, 8'h22, 0, 0, 1);
        step(); expo("c3.t3", 1, 8'h33, 0, 0, 1);
        step(); expo("c3.commit", 0, 8'h00, 1, 0, 1);
        step(); expo("c3.idle", 0, 8'h00, 0, 1, 0);

        drive(2'd1, 8'hA5, 8'h5A, 8'hC3);
        step(); in_valid = 1'b0;
        expo("c1.t1", 1, 8'hA5, 0, 0, 1);
        step(); expo("c1.commit", 0, 8'h00, 1, 0, 1);
        step(); expo("c1.idle", 0, 8'h00, 0, 1, 0);

        drive(2'd0, 8'hDE, 8'hAD, 8'hBE);
        step(); in_valid = 1'b0;
        expo("c0.commit", 0, 8'h00, 1, 0, 1);
        step(); expo("c0.idle", 0, 8'h00, 0, 1, 0);

        drive(2'd2, 8'h01, 8'h02, 8'h03);
        step(); expo("b2b.a1", 1, 8'h01, 0, 0, 1);
        drive(2'd3, 8'h04, 8'h05, 8'h06);
        step(); expo("b2b.a2", 1, 8'h02, 0, 0, 1);
        step(); expo("b2b.acommit", 0, 8'h00, 1, 0, 1);
        step(); expo("b2b.accept", 0, 8'h00, 0, 1, 0);
        step(); in_valid = 1'b0;
        expo("b2b.b1", 1, 8'h04, 0, 0, 1);
        step(); expo("b2b.b2", 1, 8'h05, 0, 0, 1);
        step(); expo("b2b.b3", 1, 8'h06, 0, 0, 1);
        step(); expo("b2b.bcommit", 0, 8'h00, 1, 0, 1);
        step(); expo("b2b.idle", 0, 8'h00, 0, 1, 0);

        n_done = 0;
        n_put = 0;
        drive(2'd2, 8'h10, 8'h20, 8'h30);
        for (int i = 0; i < 20; i++) begin
            step();
            n_done += int'(cmd_done);
            n_put += int'(put);
            if (i == 19) in_valid = 1'b0;
        end
        chk("thru.commits", 32'(n_done), 32'd5);
        chk("thru.puts", 32'(n_put), 32'd10);
        step(); expo("thru.idle", 0, 8'h00, 0, 1, 0);

        drive(2'd3, 8'h77, 8'h88, 8'h99);
        step(); in_valid = 1'b0;
        expo("rst.t1", 1, 8'h77, 0, 0, 1);
        step(); expo("rst.t2", 1, 8'h88, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1 expo("rst.async", 0, 8'h00, 0, 0, 0);
        step(); expo("rst.held", 0, 8'h00, 0, 0, 0);
        rst_n = 1'b1;
        #1 expo("rst.release", 0, 8'h00, 0, 1, 0);
        drive(2'd2, 8'h3C, 8'hC3, 8'hFF);
        step(); in_valid = 1'b0;
        expo("rst.n1", 1, 8'h3C, 0, 0, 1);
        step(); expo("rst.n2", 1, 8'hC3, 0, 0, 1);
        step(); expo("rst.ncommit", 0, 8'h00, 1, 0, 1);
        step(); expo("rst.nidle", 0, 8'h00, 0, 1, 0);

        for (int k = 0; k < 6; k++) begin
            cnt = 2'($urandom_range(0, 3));
            for (int j = 0; j < 3; j++) ops[j] = 8'($urandom_range(1, 255));
            drive(cnt, ops[0], ops[1], ops[2]);
            step(); in_valid = 1'b0;
            for (int j = 0; j < int'(cnt); j++) begin
                expo($sformatf("rnd%0d.op%0d", k, j), 1, ops[j], 0, 0, 1);
                step();
            end
            expo($sformatf("rnd%0d.commit", k), 0, 8'h00, 1, 0, 1);
            step();
            expo($sformatf("rnd%0d.idle", k), 0, 8'h00, 0, 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
